axis_frame_gen: RTL and testbench
=================================

AXIS_FRAME_GEN -- requirements
Module: axis_frame_gen

Interface
REQ-001 Parameter TDATA_WIDTH, default 32: stream data width in bits; multiple of 8, range 8..512.
REQ-002 Parameter NUM_CH, default 4: number of destination channels rotated through tdest; range 1..16.
REQ-003 Parameter LEN_WIDTH, default 16: width of frame_len in bytes.
REQ-004 Parameter CNT_WIDTH, default 16: width of num_frames, gap_cycles and frame_count.
REQ-005 aclk  in  1  sole clock; all logic rising-edge.
REQ-006 areset  in  1  synchronous, active-high reset.
REQ-007 start  in  1  single-cycle pulse that latches configuration and begins a run.
REQ-008 stop  in  1  pulse requesting graceful stop after the current frame.
REQ-009 frame_len  in  LEN_WIDTH  frame length in bytes.
REQ-010 num_frames  in  CNT_WIDTH  frames per run; 0 means run until stop.
REQ-011 gap_cycles  in  CNT_WIDTH  idle cycles inserted between frames.
REQ-012 mode  in  1  0 = counter pattern, 1 = PRBS pattern.
REQ-013 m_axis_tdata / tkeep / tdest / tlast / tvalid  out  TDATA_WIDTH / TDATA_WIDTH/8 / clog2(NUM_CH) (min 1) / 1 / 1  AXI-Stream master.
REQ-014 m_axis_tready  in  1  AXI-Stream back-pressure.
REQ-015 busy  out  1  high from the cycle after an accepted start until the run ends.
REQ-016 done  out  1  one-cycle pulse when a run ends.
REQ-017 frame_count  out  CNT_WIDTH  frames completed in the current or last run; wraps modulo 2^CNT_WIDTH.

Function
REQ-018 FSM states IDLE, SEND, GAP; IDLE --start & frame_len!=0--> SEND; start with frame_len==0, or start while busy, SHALL be ignored.
REQ-019 On start the block SHALL latch frame_len, num_frames, gap_cycles and mode, clear frame_count, and set tdest=0; tvalid rises the next cycle.
REQ-020 A beat transfers when tvalid & tready; while tvalid=1 and tready=0, tdata/tkeep/tdest/tlast SHALL hold stable.
REQ-021 Beats per frame = ceil(frame_len / (TDATA_WIDTH/8)); tlast=1 only on the final beat; tkeep all-ones except the final beat, which SHALL set the low (frame_len mod bytes) bits, or all bits when the remainder is 0.
REQ-022 Counter mode: byte k of frame f (lane k mod bytes) SHALL equal (k + f) mod 256, where f = frame index within the run.
REQ-023 tdest SHALL increment by 1 modulo NUM_CH after each completed frame.
REQ-024 After the last beat: frame_count increments; if (num_frames!=0 and frame_count reaches num_frames) or stop is pending -> IDLE with done=1 that cycle; otherwise gap_cycles==0 -> SEND with no bubble, else GAP.
REQ-025 GAP SHALL hold tvalid=0 for exactly gap_cycles cycles, then enter SEND; stop during GAP SHALL go to IDLE with done=1 on the next cycle.
REQ-026 stop SHALL never truncate a frame; stop in IDLE is ignored; stop is held pending until acted on.

Reset
REQ-027 areset SHALL, at the next edge, force IDLE, tvalid=0, tlast=0, busy=0, done=0, frame_count=0, tdata=0, tkeep=0, tdest=0, clear pending stop; a frame in flight is abandoned without tlast.

Configuration
REQ-028 Macro AXIS_FRAME_GEN_PRBS_EN defined: mode=1 produces PRBS-31 (x^31+x^28+1) data, LFSR seeded 0x7FFFFFFF at start, advanced TDATA_WIDTH bits per transferred beat, bit 0 of tdata = first generated bit; state persists across frames within a run.
REQ-029 Macro undefined: no LFSR logic; mode is ignored and counter pattern is always used.

Structure
REQ-030 Package axis_frame_gen_pkg SHALL hold the FSM state enum, the mode enum, and the PRBS-31 seed/tap constants.
REQ-031 The LFSR SHALL be sub-module axis_frame_gen_prbs (parallel TDATA_WIDTH-bit step, enable, load), instantiated only under AXIS_FRAME_GEN_PRBS_EN.

Verification (TDATA_WIDTH=32, NUM_CH=4)
REQ-032 frame_len=10, num_frames=2, gap=3, tready=1 -> 2 frames of 3 beats, last tkeep=4'b0011, tdest 0 then 1, 3 idle cycles between, done once, frame_count=2.
REQ-033 Same config, tready random 50% -> identical byte sequence; no tdata/tlast change while tvalid & !tready.
REQ-034 frame_len=8, gap=0, num_frames=3 -> 6 consecutive tvalid beats with no bubble, tlast on beats 2, 4, 6; frame 1 first word 32'h04030201.
REQ-035 num_frames=0, stop pulsed on beat 2 of frame 5 -> frame 5 completes with tlast, done next, frame_count=5, tdest wraps 3->0 at frame 5.
REQ-036 areset asserted mid-frame -> tvalid=0 and busy=0 next cycle; following start restarts at frame 0, byte 0.
REQ-037 PRBS build, mode=1, frame_len=4 -> first beat equals first 32 bits of reference PRBS-31 from seed 0x7FFFFFFF; non-PRBS build gives counter data 32'h03020100.

Source files
------------

// File: rtl/axis_frame_gen_pkg.sv
// Shared types and constants for the AXI-Stream frame generator.
// The PRBS constants are used only when AXIS_FRAME_GEN_PRBS_EN is defined.
package axis_frame_gen_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_GAP  = 2'd2
    } fsm_state_t;

    typedef enum logic {
        MODE_COUNTER = 1'b0,
        MODE_PRBS    = 1'b1
    } gen_mode_t;

    // PRBS-31, x^31 + x^28 + 1, Fibonacci form shifting towards the MSB
    localparam int unsigned PRBS_LEN   = 31;
    localparam logic [30:0] PRBS_SEED  = 31'h7FFF_FFFF;
    localparam int unsigned PRBS_TAP_A = 30;
    localparam int unsigned PRBS_TAP_B = 27;

endpackage

// File: rtl/axis_frame_gen_prbs.sv
// PRBS-31 generator that advances WIDTH bits per enabled cycle.
// data[0] is the first bit generated from the current LFSR state.
module axis_frame_gen_prbs
    import axis_frame_gen_pkg::*;
#(
    parameter int unsigned WIDTH = 32
)(
    input  logic             aclk,
    input  logic             areset,
    input  logic             load,
    input  logic             en,
    output logic [WIDTH-1:0] data
);

    logic [PRBS_LEN-1:0] lfsr;
    logic [PRBS_LEN-1:0] lfsr_step;
    logic [PRBS_LEN-1:0] walk;

    // Unroll WIDTH serial shifts to get this beat's bits and the next state
    always_comb begin
        walk = lfsr;
        data = '0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            data[i] = walk[PRBS_TAP_A] ^ walk[PRBS_TAP_B];
            walk    = {walk[PRBS_LEN-2:0], data[i]};
        end
        lfsr_step = walk;
    end

    // LFSR state: reseeded on load, advanced once per transferred beat
    always_ff @(posedge aclk) begin
        if (areset) begin
            lfsr <= PRBS_SEED;
        end else if (load) begin
            lfsr <= PRBS_SEED;
        end else if (en) begin
            lfsr <= lfsr_step;
        end
    end

endmodule

// File: rtl/axis_frame_gen.sv
// AXI-Stream frame generator: emits runs of fixed-length frames with a
// counter (or, with AXIS_FRAME_GEN_PRBS_EN defined, PRBS-31) payload,
// rotating tdest per frame and inserting programmable idle gaps.
module axis_frame_gen
    import axis_frame_gen_pkg::*;
#(
    parameter int unsigned TDATA_WIDTH = 32,
    parameter int unsigned NUM_CH      = 4,
    parameter int unsigned LEN_WIDTH   = 16,
    parameter int unsigned CNT_WIDTH   = 16,
    localparam int unsigned KEEP_WIDTH = TDATA_WIDTH / 8,
    localparam int unsigned DEST_WIDTH = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
)(
    input  logic                   aclk,
    input  logic                   areset,
    input  logic                   start,
    input  logic                   stop,
    input  logic [LEN_WIDTH-1:0]   frame_len,
    input  logic [CNT_WIDTH-1:0]   num_frames,
    input  logic [CNT_WIDTH-1:0]   gap_cycles,
    input  logic                   mode,
    output logic [TDATA_WIDTH-1:0] m_axis_tdata,
    output logic [KEEP_WIDTH-1:0]  m_axis_tkeep,
    output logic [DEST_WIDTH-1:0]  m_axis_tdest,
    output logic                   m_axis_tlast,
    output logic                   m_axis_tvalid,
    input  logic                   m_axis_tready,
    output logic                   busy,
    output logic                   done,
    output logic [CNT_WIDTH-1:0]   frame_count
);

    fsm_state_t state;
    fsm_state_t state_next;

    logic [LEN_WIDTH-1:0]   len_lat;
    logic [LEN_WIDTH-1:0]   bytes_left;
    logic [CNT_WIDTH-1:0]   num_lat;
    logic [CNT_WIDTH-1:0]   gap_lat;
    logic [CNT_WIDTH-1:0]   gap_cnt;
    logic [CNT_WIDTH-1:0]   frame_count_r;
    logic [7:0]             byte_base;
    logic [7:0]             frame_idx;
    logic [DEST_WIDTH-1:0]  dest_r;
    logic                   stop_pend;
    logic                   done_r;

    logic                   tvalid_int;
    logic                   start_ok;
    logic                   xfer;
    logic                   last_beat;
    logic                   frame_end;
    logic                   quota_hit;
    logic                   stop_eff;
    logic [TDATA_WIDTH-1:0] cnt_data;
    logic [TDATA_WIDTH-1:0] gen_data;
    logic [KEEP_WIDTH-1:0]  last_keep;

    assign start_ok  = (state == ST_IDLE) && start && (frame_len != '0);
    assign xfer      = tvalid_int && m_axis_tready;
    assign last_beat = (bytes_left <= LEN_WIDTH'(KEEP_WIDTH));
    assign frame_end = xfer && last_beat;
    assign stop_eff  = stop_pend || stop;
    assign quota_hit = (num_lat != '0) && ((frame_count_r + CNT_WIDTH'(1)) == num_lat);

`ifdef AXIS_FRAME_GEN_PRBS_EN
    gen_mode_t              mode_lat;
    logic [TDATA_WIDTH-1:0] prbs_data;

    axis_frame_gen_prbs #(
        .WIDTH (TDATA_WIDTH)
    ) u_prbs (
        .aclk   (aclk),
        .areset (areset),
        .load   (start_ok),
        .en     (xfer),
        .data   (prbs_data)
    );

    // Pattern selection is frozen for the whole run
    always_ff @(posedge aclk) begin
        if (areset) begin
            mode_lat <= MODE_COUNTER;
        end else if (start_ok) begin
            mode_lat <= gen_mode_t'(mode);
        end
    end

    assign gen_data = (mode_lat == MODE_PRBS) ? prbs_data : cnt_data;
`else
    logic unused_mode;

    assign unused_mode = mode;
    assign gen_data    = cnt_data;
`endif

    // FSM state register
    always_ff @(posedge aclk) begin
        if (areset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // FSM next-state: frames are never cut short, stop is honoured at frame or gap boundaries
    always_comb begin
        state_next = state;
        unique case (state)
            ST_IDLE: begin
                if (start_ok) begin
                    state_next = ST_SEND;
                end
            end
            ST_SEND: begin
                if (frame_end) begin
                    if (quota_hit || stop_eff) begin
                        state_next = ST_IDLE;
                    end else if (gap_lat == '0) begin
                        state_next = ST_SEND;
                    end else begin
                        state_next = ST_GAP;
                    end
                end
            end
            ST_GAP: begin
                if (stop_eff) begin
                    state_next = ST_IDLE;
                end else if (gap_cnt == CNT_WIDTH'(1)) begin
                    state_next = ST_SEND;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // FSM outputs: stream signals are pure functions of held state, so they stay stable under back-pressure
    always_comb begin
        tvalid_int    = (state == ST_SEND);
        busy          = (state != ST_IDLE);
        m_axis_tvalid = tvalid_int;
        m_axis_tlast  = tvalid_int && last_beat;
        m_axis_tdata  = tvalid_int ? gen_data : '0;
        m_axis_tkeep  = '0;
        if (tvalid_int) begin
            m_axis_tkeep = last_beat ? last_keep : '1;
        end
        m_axis_tdest  = dest_r;
        done          = done_r;
        frame_count   = frame_count_r;
    end

    // Counter payload and final-beat byte mask; bytes_left equals the remainder (or full width) on the last beat
    always_comb begin
        cnt_data  = '0;
        last_keep = '0;
        for (int unsigned i = 0; i < KEEP_WIDTH; i++) begin
            cnt_data[8*i +: 8] = byte_base + 8'(i);
            last_keep[i]       = (bytes_left > LEN_WIDTH'(i));
        end
    end

    // Run configuration, frame/beat tracking, gap timing, stop request and done pulse
    always_ff @(posedge aclk) begin
        if (areset) begin
            len_lat       <= '0;
            bytes_left    <= '0;
            num_lat       <= '0;
            gap_lat       <= '0;
            gap_cnt       <= '0;
            frame_count_r <= '0;
            byte_base     <= '0;
            frame_idx     <= '0;
            dest_r        <= '0;
            stop_pend     <= 1'b0;
            done_r        <= 1'b0;
        end else begin
            done_r <= (state != ST_IDLE) && (state_next == ST_IDLE);

            if ((state == ST_IDLE) || (state_next == ST_IDLE)) begin
                stop_pend <= 1'b0;
            end else if (stop) begin
                stop_pend <= 1'b1;
            end

            if (start_ok) begin
                len_lat       <= frame_len;
                num_lat       <= num_frames;
                gap_lat       <= gap_cycles;
                bytes_left    <= frame_len;
                frame_count_r <= '0;
                byte_base     <= '0;
                frame_idx     <= '0;
                dest_r        <= '0;
            end else if (xfer) begin
                if (last_beat) begin
                    frame_count_r <= frame_count_r + CNT_WIDTH'(1);
                    frame_idx     <= frame_idx + 8'd1;
                    byte_base     <= frame_idx + 8'd1;
                    bytes_left    <= len_lat;
                    gap_cnt       <= gap_lat;
                    dest_r        <= (dest_r == DEST_WIDTH'(NUM_CH - 1)) ? '0
                                                                         : dest_r + DEST_WIDTH'(1);
                end else begin
                    bytes_left <= bytes_left - LEN_WIDTH'(KEEP_WIDTH);
                    byte_base  <= byte_base + 8'(KEEP_WIDTH);
                end
            end else if (state == ST_GAP) begin
                gap_cnt <= gap_cnt - CNT_WIDTH'(1);
            end
        end
    end

endmodule

// File: tb/tb_axis_frame_gen.sv
// Scoreboard bench for axis_frame_gen (32-bit data, 4 channels).
// Define AXIS_FRAME_GEN_PRBS_EN for both RTL and bench to check the PRBS build.
module tb_axis_frame_gen;

    localparam int unsigned DW  = 32;
    localparam int unsigned NCH = 4;
    localparam int unsigned LW  = 16;
    localparam int unsigned CW  = 16;

    logic          aclk;
    logic          areset;
    logic          start;
    logic          stop;
    logic [LW-1:0] frame_len;
    logic [CW-1:0] num_frames;
    logic [CW-1:0] gap_cycles;
    logic          mode;
    logic [DW-1:0] tdata;
    logic [3:0]    tkeep;
    logic [1:0]    tdest;
    logic          tlast;
    logic          tvalid;
    logic          tready;
    logic          busy;
    logic          done;
    logic [CW-1:0] frame_count;

    axis_frame_gen #(
        .TDATA_WIDTH (DW),
        .NUM_CH      (NCH),
        .LEN_WIDTH   (LW),
        .CNT_WIDTH   (CW)
    ) dut (
        .aclk          (aclk),
        .areset        (areset),
        .start         (start),
        .stop          (stop),
        .frame_len     (frame_len),
        .num_frames    (num_frames),
        .gap_cycles    (gap_cycles),
        .mode          (mode),
        .m_axis_tdata  (tdata),
        .m_axis_tkeep  (tkeep),
        .m_axis_tdest  (tdest),
        .m_axis_tlast  (tlast),
        .m_axis_tvalid (tvalid),
        .m_axis_tready (tready),
        .busy          (busy),
        .done          (done),
        .frame_count   (frame_count)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    typedef struct {
        logic [31:0] data;
        logic [3:0]  keep;
        logic [1:0]  dest;
        logic        last;
    } beat_t;

    beat_t       sb[$];
    int unsigned total = 0;
    int unsigned bad   = 0;

    logic        rnd_en   = 1'b0;
    int unsigned exp_gap  = 0;
    int unsigned done_cnt = 0;
    int unsigned mon_frame = 0;
    int unsigned mon_beat  = 0;
    int unsigned idle      = 0;
    logic        gap_armed = 1'b0;
    logic        held_v    = 1'b0;
    logic [38:0] held;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] prbs_first_word();
        logic [30:0] s;
        logic [31:0] w;
        logic        nb;
        s = 31'h7FFF_FFFF;
        w = '0;
        for (int i = 0; i < 32; i++) begin
            nb   = s[30] ^ s[27];
            w[i] = nb;
            s    = {s[29:0], nb};
        end
        return w;
    endfunction

    task automatic push_counter_run(input int len, input int nfr);
        beat_t bt;
        int    beats;
        beats = (len + 3) / 4;
        for (int f = 0; f < nfr; f++) begin
            for (int b = 0; b < beats; b++) begin
                for (int l = 0; l < 4; l++) begin
                    bt.data[8*l +: 8] = 8'((b * 4 + l + f) % 256);
                end
                bt.last = (b == beats - 1);
                bt.keep = bt.last ? 4'((1 << (len - b * 4)) - 1) : 4'hF;
                bt.dest = 2'(f % 4);
                sb.push_back(bt);
            end
        end
    endtask

    // tready: held high, or a fresh coin flip each cycle
    always @(posedge aclk) begin
        #1;
        tready = rnd_en ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    // Monitor: scoreboard pop on transfer, stall stability, inter-frame gap length, done pulses
    always @(negedge aclk) begin
        beat_t exp_b;
        if (areset) begin
            held_v    = 1'b0;
            gap_armed = 1'b0;
        end else begin
            if (done) done_cnt++;
            if (!busy) begin
                gap_armed = 1'b0;
                mon_frame = 0;
                mon_beat  = 0;
                idle      = 0;
            end
            if (held_v) begin
                check_val("hold_valid", 64'(tvalid), 64'd1);
                check_val("hold_beat", 64'({tdata, tkeep, tdest, tlast}), 64'(held));
                held_v = 1'b0;
            end
            if (tvalid && !tready) begin
                held_v = 1'b1;
                held   = {tdata, tkeep, tdest, tlast};
            end
            if (tvalid) begin
                if (gap_armed) begin
                    check_val("gap_len", 64'(idle), 64'(exp_gap));
                    gap_armed = 1'b0;
                end
            end else if (gap_armed) begin
                idle++;
            end
            if (tvalid && tready) begin
                if (sb.size() == 0) begin
                    check_val("unexpected_beat", 64'd1, 64'd0);
                end else begin
                    exp_b = sb.pop_front();
                    check_val("tdata", 64'(tdata), 64'(exp_b.data));
                    check_val("tkeep", 64'(tkeep), 64'(exp_b.keep));
                    check_val("tdest", 64'(tdest), 64'(exp_b.dest));
                    check_val("tlast", 64'(tlast), 64'(exp_b.last));
                end
                if (tlast) begin
                    gap_armed = 1'b1;
                    idle      = 0;
                    mon_frame++;
                    mon_beat  = 0;
                end else begin
                    mon_beat++;
                end
            end
        end
    end

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic start_run(input int len, input int nfr, input int gap, input logic md);
        frame_len  = LW'(len);
        num_frames = CW'(nfr);
        gap_cycles = CW'(gap);
        mode       = md;
        start      = 1'b1;
        tick();
        start      = 1'b0;
    endtask

    task automatic finish_run(input string tag, input int exp_frames, input int d0);
        int n;
        n = 0;
        while (done_cnt == d0 && n < 3000) begin
            tick();
            n++;
        end
        if (n >= 3000) check_val({tag, "_timeout"}, 64'd1, 64'd0);
        repeat (4) tick();
        check_val({tag, "_done_once"}, 64'(done_cnt - d0), 64'd1);
        check_val({tag, "_frame_count"}, 64'(frame_count), 64'(exp_frames));
        check_val({tag, "_sb_drained"}, 64'(sb.size()), 64'd0);
        check_val({tag, "_busy_low"}, 64'(busy), 64'd0);
    endtask

    initial begin
        int d0;
        int n;
        beat_t bt;
        areset = 1'b1; start = 1'b0; stop = 1'b0;
        frame_len = '0; num_frames = '0; gap_cycles = '0; mode = 1'b0;
        repeat (3) tick();
        areset = 1'b0;
        check_val("rst_tvalid", 64'(tvalid), 64'd0);
        check_val("rst_tlast", 64'(tlast), 64'd0);
        check_val("rst_busy", 64'(busy), 64'd0);
        check_val("rst_done", 64'(done), 64'd0);
        check_val("rst_frame_count", 64'(frame_count), 64'd0);
        check_val("rst_tdata", 64'(tdata), 64'd0);
        check_val("rst_tkeep", 64'(tkeep), 64'd0);
        check_val("rst_tdest", 64'(tdest), 64'd0);

        // zero-length start and stop in idle are ignored
        start_run(0, 2, 0, 1'b0);
        stop = 1'b1; tick(); stop = 1'b0;
        repeat (2) tick();
        check_val("len0_busy", 64'(busy), 64'd0);
        check_val("len0_tvalid", 64'(tvalid), 64'd0);

        // 10-byte frames, 3-cycle gap, full throughput
        exp_gap = 3; d0 = done_cnt;
        push_counter_run(10, 2);
        start_run(10, 2, 3, 1'b0);
        check_val("t1_busy_after_start", 64'(busy), 64'd1);
        check_val("t1_tvalid_after_start", 64'(tvalid), 64'd1);
        finish_run("t1", 2, d0);

        // same run under random back-pressure
        rnd_en = 1'b1; d0 = done_cnt;
        push_counter_run(10, 2);
        start_run(10, 2, 3, 1'b0);
        finish_run("t2", 2, d0);
        rnd_en = 1'b0;

        // back-to-back 8-byte frames, plus a start while busy that must be ignored
        exp_gap = 0; d0 = done_cnt;
        push_counter_run(8, 3);
        start_run(8, 3, 0, 1'b0);
        tick();
        start_run(4, 1, 5, 1'b0);
        finish_run("t3", 3, d0);

        // endless run stopped during the second beat of the fifth frame
        exp_gap = 1; d0 = done_cnt;
        push_counter_run(10, 5);
        start_run(10, 0, 1, 1'b0);
        n = 0;
        while (!(mon_frame == 4 && mon_beat == 1) && n < 2000) begin
            tick();
            n++;
        end
        if (n >= 2000) check_val("t4_stop_wait_timeout", 64'd1, 64'd0);
        stop = 1'b1; tick(); stop = 1'b0;
        finish_run("t4", 5, d0);

        // reset in the middle of a frame, then a fresh run from byte 0
        exp_gap = 0; d0 = done_cnt;
        push_counter_run(40, 1);
        start_run(40, 1, 0, 1'b0);
        n = 0;
        while (mon_beat < 3 && n < 200) begin
            tick();
            n++;
        end
        areset = 1'b1;
        tick();
        check_val("t5_tvalid_after_rst", 64'(tvalid), 64'd0);
        check_val("t5_busy_after_rst", 64'(busy), 64'd0);
        check_val("t5_tlast_after_rst", 64'(tlast), 64'd0);
        check_val("t5_count_after_rst", 64'(frame_count), 64'd0);
        areset = 1'b0;
        sb.delete();
        tick();
        d0 = done_cnt;
        push_counter_run(4, 1);
        start_run(4, 1, 0, 1'b0);
        finish_run("t5", 1, d0);

        // pattern-mode run: PRBS in the PRBS build, counter otherwise
        d0 = done_cnt;
`ifdef AXIS_FRAME_GEN_PRBS_EN
        bt.data = prbs_first_word();
`else
        bt.data = 32'h0302_0100;
`endif
        bt.keep = 4'hF;
        bt.dest = 2'd0;
        bt.last = 1'b1;
        sb.push_back(bt);
        start_run(4, 1, 0, 1'b1);
        finish_run("t6", 1, d0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
